// File: rtl/frac_bit_strobe_pkg.sv
// Shared types and constants for the fractional bit-rate strobe generator.
//   state_t    : IDLE / RUN controller state
//   MIN_DIV    : smallest integer period the counter supports
//   DEF_CNT_W  : default width of the integer divisor / period down-counter
//   DEF_FRAC_W : default width of the fractional numerator / denominator
package frac_bit_strobe_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int MIN_DIV    = 2;
  localparam int DEF_CNT_W  = 8;
  localparam int DEF_FRAC_W = 4;

endpackage

// File: rtl/frac_phase_accum.sv
// Combinational period-load computation for frac_bit_strobe.
// Given the current phase accumulator and the divisor settings it returns the
// length of the next bit period, the accumulator value to store with it, and
// the configuration-error flag.
// Ports:
//   acc          in  FRAC_W   current phase accumulator
//   div_int      in  CNT_W    integer part of the period
//   div_num      in  FRAC_W   fractional numerator
//   div_den      in  FRAC_W   fractional denominator
//   per          out CNT_W+1  period P for the next bit (2 .. 2^CNT_W)
//   acc_next     out FRAC_W   accumulator value that goes with P
//   cfg_err_next out 1        divisor settings are out of range
module frac_phase_accum
  import frac_bit_strobe_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic [FRAC_W-1:0] acc,
  input  logic [CNT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_num,
  input  logic [FRAC_W-1:0] div_den,
  output logic [CNT_W:0]    per,
  output logic [FRAC_W-1:0] acc_next,
  output logic              cfg_err_next
);

  logic [CNT_W:0]  ie;
  logic [FRAC_W:0] sum;
  logic [FRAC_W:0] sum_wrap;
  logic            int_low;
  logic            frac_ok;

  always_comb begin
    int_low  = (div_int < CNT_W'(MIN_DIV));
    // One bit wider than div_int so ie+1 reaches 2^CNT_W without wrapping.
    ie       = int_low ? (CNT_W+1)'(MIN_DIV) : {1'b0, div_int};
    frac_ok  = (div_den != '0) && (div_num < div_den);
    sum      = {1'b0, acc} + {1'b0, div_num};
    sum_wrap = sum - {1'b0, div_den};

    per      = ie;
    acc_next = acc;
    if (frac_ok) begin
      if (sum >= {1'b0, div_den}) begin
        per      = ie + (CNT_W+1)'(1);
        acc_next = sum_wrap[FRAC_W-1:0];
      end else begin
        acc_next = sum[FRAC_W-1:0];
      end
    end

    cfg_err_next = ((div_den != '0) && (div_num >= div_den)) || int_low;
  end

endmodule

// File: rtl/frac_bit_strobe.sv
// Fractional bit-rate strobe generator.
// Emits a one-cycle strobe on the last clock of every bit period, where the
// period averages div_int + div_num/div_den clocks, plus a mid-bit strobe.
// A resync pulse restarts the current bit period (RX edge alignment).
// Optional build macro FRAC_BIT_STROBE_BITCNT_EN adds a bit-in-byte counter
// (bit_idx) and a byte_tick output.
// Ports:
//   clk        in  1       system clock
//   rst        in  1       asynchronous active-high reset
//   enable     in  1       run request; low returns to IDLE
//   clear      in  1       synchronous return to IDLE with accumulator zeroed
//   resync     in  1       restart the current bit period
//   div_int    in  CNT_W   integer part of the period
//   div_num    in  FRAC_W  fractional numerator
//   div_den    in  FRAC_W  fractional denominator
//   strobe     out 1       last clock of each bit period
//   mid_strobe out 1       mid-bit sample point
//   running    out 1       controller is in RUN
//   cfg_err    out 1       registered divisor-range error
//   state_dbg  out state_t controller state, for observation
//   bit_idx    out 3       (macro only) bit position within the byte
//   byte_tick  out 1       (macro only) strobe of the 8th bit
//
// Handshake: there is no valid/ready pair; strobe and mid_strobe are single
// cycle pulses decoded from registers only, so they never depend
// combinationally on any input.
module frac_bit_strobe
  import frac_bit_strobe_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clear,
  input  logic              resync,
  input  logic [CNT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_num,
  input  logic [FRAC_W-1:0] div_den,
  output logic              strobe,
  output logic              mid_strobe,
  output logic              running,
  output logic              cfg_err,
  output state_t            state_dbg
`ifdef FRAC_BIT_STROBE_BITCNT_EN
  ,
  output logic [2:0]        bit_idx,
  output logic              byte_tick
`endif
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W:0]    per_q, per_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              cfg_err_q;

  logic [CNT_W:0]    ld_per;
  logic [CNT_W:0]    ld_per_m1;
  logic [CNT_W:0]    per_q_m1;
  logic [FRAC_W-1:0] ld_acc;
  logic              cfg_err_next;

  frac_phase_accum #(
    .CNT_W  (CNT_W),
    .FRAC_W (FRAC_W)
  ) u_phase (
    .acc          (acc_q),
    .div_int      (div_int),
    .div_num      (div_num),
    .div_den      (div_den),
    .per          (ld_per),
    .acc_next     (ld_acc),
    .cfg_err_next (cfg_err_next)
  );

  // Periods never exceed 2^CNT_W, so P-1 always fits in the counter.
  assign ld_per_m1 = ld_per - (CNT_W+1)'(1);
  assign per_q_m1  = per_q - (CNT_W+1)'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (clear) begin
          acc_d = '0;
        end else if (enable) begin
          state_d = RUN;
          per_d   = ld_per;
          cnt_d   = ld_per_m1[CNT_W-1:0];
          acc_d   = ld_acc;
        end
      end
      RUN: begin
        if (clear || !enable) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (clear) acc_d = '0;
        end else if (resync) begin
          // Restart with the period already in force; a coincident
          // boundary load is skipped so the accumulator does not advance.
          cnt_d = per_q_m1[CNT_W-1:0];
        end else if (cnt_q == '0) begin
          per_d = ld_per;
          cnt_d = ld_per_m1[CNT_W-1:0];
          acc_d = ld_acc;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      per_q     <= '0;
      acc_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      per_q     <= per_d;
      acc_q     <= acc_d;
      cfg_err_q <= cfg_err_next;
    end
  end

  assign running    = (state_q == RUN);
  assign strobe     = running && (cnt_q == '0);
  assign mid_strobe = running && ({1'b0, cnt_q} == (per_q >> 1));
  assign cfg_err    = cfg_err_q;
  assign state_dbg  = state_q;

`ifdef FRAC_BIT_STROBE_BITCNT_EN
  logic [2:0] bit_idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_idx_q <= 3'd0;
    end else if (state_d != RUN) begin
      bit_idx_q <= 3'd0;
    end else if (strobe) begin
      bit_idx_q <= bit_idx_q + 3'd1;
    end
  end

  assign bit_idx   = bit_idx_q;
  assign byte_tick = strobe && (bit_idx_q == 3'd7);
`endif

endmodule
